// File: rtl/l1_mau_arb_if.sv
// Bundle of L1I, L1D and memory-side signals around the shared MAU port.
// The arbiter uses the slave view; the requesters/memory environment use the master view.
interface l1_mau_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 128
);
    logic                    l1i_req_val;
    logic [ADDR_WIDTH-1:0]   l1i_req_addr;
    logic                    l1i_req_ack;
    logic [LINE_WIDTH-1:0]   l1i_ack_data;

    logic                    l1d_req_val;
    logic                    l1d_req_cop;
    logic [ADDR_WIDTH-1:0]   l1d_req_addr;
    logic [DATA_WIDTH-1:0]   l1d_req_wdata;
    logic [DATA_WIDTH/8-1:0] l1d_req_be;
    logic                    l1d_req_ack;
    logic [LINE_WIDTH-1:0]   l1d_ack_data;

    logic                    mem_req_val;
    logic                    mem_req_cop;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [DATA_WIDTH-1:0]   mem_req_wdata;
    logic [DATA_WIDTH/8-1:0] mem_req_be;
    logic                    mem_req_ack;
    logic [LINE_WIDTH-1:0]   mem_ack_data;

    logic                    err_timeout;

    modport slave (
        input  l1i_req_val, l1i_req_addr,
        output l1i_req_ack, l1i_ack_data,
        input  l1d_req_val, l1d_req_cop, l1d_req_addr, l1d_req_wdata, l1d_req_be,
        output l1d_req_ack, l1d_ack_data,
        output mem_req_val, mem_req_cop, mem_req_addr, mem_req_wdata, mem_req_be,
        input  mem_req_ack, mem_ack_data,
        output err_timeout
    );

    modport master (
        output l1i_req_val, l1i_req_addr,
        input  l1i_req_ack, l1i_ack_data,
        output l1d_req_val, l1d_req_cop, l1d_req_addr, l1d_req_wdata, l1d_req_be,
        input  l1d_req_ack, l1d_ack_data,
        input  mem_req_val, mem_req_cop, mem_req_addr, mem_req_wdata, mem_req_be,
        output mem_req_ack, mem_ack_data,
        input  err_timeout
    );
endinterface

// File: rtl/l1_mau_arb.sv
// Round-robin arbiter sharing the single MAU port between L1I and L1D,
// one outstanding transaction, fully registered outputs.
//
// state  | meaning
// IDLE   | no transaction; grant a pending request
// WAIT   | memory request outstanding, waiting for mem_req_ack
// RESP   | one-cycle acknowledge to the granted requester
module l1_mau_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WIDTH = 128,
    parameter int TIMEOUT    = 255
) (
    input logic          clk,
    input logic          rst,
    l1_mau_arb_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_grant;
    logic                    w_grant_d;

    logic                    r_last_grant;
    logic                    r_grant_id;
    logic                    r_mem_val;
    logic                    r_mem_cop;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [DATA_WIDTH/8-1:0] r_mem_be;
    logic [LINE_WIDTH-1:0]   r_resp;
    logic                    r_l1i_ack;
    logic                    r_l1d_ack;
    logic [7:0]              r_cnt;
    logic                    r_err;

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.l1i_req_val || bus.l1d_req_val) begin
                    w_grant   = 1'b1;
                    // On contention the side that did not win last time goes
                    w_grant_d = bus.l1d_req_val && (!bus.l1i_req_val || !r_last_grant);
                    w_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_req_ack) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_mem_val    <= 1'b0;
            r_mem_cop    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_resp       <= '0;
            r_l1i_ack    <= 1'b0;
            r_l1d_ack    <= 1'b0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_l1i_ack <= 1'b0;
            r_l1d_ack <= 1'b0;
            if (w_grant) begin
                r_last_grant <= w_grant_d;
                r_grant_id   <= w_grant_d;
                r_mem_val    <= 1'b1;
                r_mem_cop    <= w_grant_d & bus.l1d_req_cop;
                r_mem_addr   <= w_grant_d ? bus.l1d_req_addr  : bus.l1i_req_addr;
                r_mem_wdata  <= w_grant_d ? bus.l1d_req_wdata : '0;
                r_mem_be     <= w_grant_d ? bus.l1d_req_be    : '0;
                r_cnt        <= '0;
            end
            if (r_state == S_WAIT) begin
                if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
                // Timeout only flags; the transaction keeps waiting
                if (!bus.mem_req_ack && (r_cnt >= TO_CNT)) r_err <= 1'b1;
                if (bus.mem_req_ack) begin
                    r_mem_val <= 1'b0;
                    r_resp    <= bus.mem_ack_data;
                    r_l1i_ack <= !r_grant_id;
                    r_l1d_ack <= r_grant_id;
                end
            end
        end
    end

    assign bus.mem_req_val   = r_mem_val;
    assign bus.mem_req_cop   = r_mem_cop;
    assign bus.mem_req_addr  = r_mem_addr;
    assign bus.mem_req_wdata = r_mem_wdata;
    assign bus.mem_req_be    = r_mem_be;
    assign bus.l1i_req_ack   = r_l1i_ack;
    assign bus.l1d_req_ack   = r_l1d_ack;
    assign bus.l1i_ack_data  = r_resp;
    assign bus.l1d_ack_data  = r_resp;
    assign bus.err_timeout   = r_err;
endmodule
